// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment scan decoder.
// Glyphs are active-high gfedcba (bit0 = a); the decimal point is handled separately.
package seg_pkg;

   localparam int NUM_DIGITS = 4;

   localparam logic [6:0] GLYPH_0     = 7'h3F;
   localparam logic [6:0] GLYPH_1     = 7'h06;
   localparam logic [6:0] GLYPH_2     = 7'h5B;
   localparam logic [6:0] GLYPH_3     = 7'h4F;
   localparam logic [6:0] GLYPH_4     = 7'h66;
   localparam logic [6:0] GLYPH_5     = 7'h6D;
   localparam logic [6:0] GLYPH_6     = 7'h7D;
   localparam logic [6:0] GLYPH_7     = 7'h07;
   localparam logic [6:0] GLYPH_8     = 7'h7F;
   localparam logic [6:0] GLYPH_9     = 7'h6F;
   localparam logic [6:0] GLYPH_A     = 7'h77;
   localparam logic [6:0] GLYPH_B     = 7'h7C;
   localparam logic [6:0] GLYPH_C     = 7'h39;
   localparam logic [6:0] GLYPH_D     = 7'h5E;
   localparam logic [6:0] GLYPH_E     = 7'h79;
   localparam logic [6:0] GLYPH_F     = 7'h71;
   localparam logic [6:0] GLYPH_BLANK = 7'h00;

   // Anode tracker states
   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      HELD
   } scanState_e;

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational glyph decoder: turns one raw active-high segment byte into a hex
// nibble plus decimal point, blank and error flags.
module seg_glyph_decode
   import seg_pkg::*;
(
   input  logic [7:0] glyph_i,
   output logic [3:0] nibble_o,
   output logic       dp_o,
   output logic       blank_o,
   output logic       err_o
);

   // Exact-match lookup of the seven segment bits; anything unknown is an error
   always_comb begin
      nibble_o = 4'h0;
      blank_o  = 1'b0;
      err_o    = 1'b0;
      dp_o     = glyph_i[7];
      case (glyph_i[6:0])
         GLYPH_0:     nibble_o = 4'h0;
         GLYPH_1:     nibble_o = 4'h1;
         GLYPH_2:     nibble_o = 4'h2;
         GLYPH_3:     nibble_o = 4'h3;
         GLYPH_4:     nibble_o = 4'h4;
         GLYPH_5:     nibble_o = 4'h5;
         GLYPH_6:     nibble_o = 4'h6;
         GLYPH_7:     nibble_o = 4'h7;
         GLYPH_8:     nibble_o = 4'h8;
         GLYPH_9:     nibble_o = 4'h9;
         GLYPH_A:     nibble_o = 4'hA;
         GLYPH_B:     nibble_o = 4'hB;
         GLYPH_C:     nibble_o = 4'hC;
         GLYPH_D:     nibble_o = 4'hD;
         GLYPH_E:     nibble_o = 4'hE;
         GLYPH_F:     nibble_o = 4'hF;
         GLYPH_BLANK: blank_o  = 1'b1;
         default:     err_o    = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive side of the multiplexed 7-segment bus: tracks the scanned anodes,
// captures each digit once it has settled, and publishes the four digits once
// the same frame has been seen several times in a row.
module seg_scan_decoder
   import seg_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 16,
   parameter int STABLE_FRAMES  = 3,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic        Clk100Mhz,
   input  logic        rst,
   input  logic [7:0]  seg,
   input  logic [3:0]  an,
   output logic [15:0] value,
   output logic [3:0]  dp,
   output logic [3:0]  blank,
   output logic [3:0]  err,
   output logic        update,
   output logic        locked
);

   localparam logic [7:0]  SETTLE_LIM  = 8'(SETTLE_CYCLES);
   localparam logic [3:0]  STABLE_LIM  = 4'(STABLE_FRAMES);
   localparam logic [20:0] TIMEOUT_LIM = 21'(TIMEOUT_CYCLES);

   logic [7:0]  seg_q;
   logic [3:0]  an_q;
   logic [3:0]  anLast_q;
   logic        anOneLow;
   logic [1:0]  anIndex;

   scanState_e  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [1:0]  idx_q, idx_d;
   logic        capture;

   logic [NUM_DIGITS-1:0][7:0] slots_q;
   logic [NUM_DIGITS-1:0][7:0] prev_q;
   logic                       prevValid_q;
   logic [NUM_DIGITS-1:0]      captured_q, captured_d;
   logic [3:0]                 match_q, match_d;
   logic                       frameClose;
   logic                       frameSame;

   logic [20:0] toCnt_q;
   logic        toReach;
   logic        locked_q;

   logic [15:0] decValue;
   logic [3:0]  decDp, decBlank, decErr;

   logic        pubPend_q;
   logic [15:0] stValue_q;
   logic [3:0]  stDp_q, stBlank_q, stErr_q;

   logic [15:0] value_q;
   logic [3:0]  dp_q, blank_q, err_q;
   logic        update_q;

   // One decoder per frame slot, so the whole frame decodes in parallel at close
   for (genvar d = 0; d < NUM_DIGITS; d++) begin : gDecode
      seg_glyph_decode uDecode (
         .glyph_i  (slots_q[d]),
         .nibble_o (decValue[4*d +: 4]),
         .dp_o     (decDp[d]),
         .blank_o  (decBlank[d]),
         .err_o    (decErr[d])
      );
   end

   // Register the pins once, and keep the previous anode sample for change detection
   always_ff @(posedge Clk100Mhz) begin
      if (rst) begin
         seg_q    <= 8'hFF;
         an_q     <= 4'hF;
         anLast_q <= 4'hF;
      end else begin
         seg_q    <= seg;
         an_q     <= an;
         anLast_q <= an_q;
      end
   end

   // Classify the anode pattern: exactly one low line selects a digit
   always_comb begin
      anOneLow = 1'b1;
      anIndex  = 2'd0;
      case (an_q)
         4'b1110: anIndex = 2'd0;
         4'b1101: anIndex = 2'd1;
         4'b1011: anIndex = 2'd2;
         4'b0111: anIndex = 2'd3;
         default: anOneLow = 1'b0;
      endcase
   end

   // Anode tracker state register
   always_ff @(posedge Clk100Mhz) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         idx_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
      end
   end

   // Anode tracker next state; a capture fires the moment the settle count is reached
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      capture = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = 8'd0;
            if (anOneLow) begin
               state_d = SETTLE;
               cnt_d   = 8'd1;
               idx_d   = anIndex;
            end
         end
         SETTLE, HELD: begin
            if (an_q != anLast_q) begin
               if (anOneLow) begin
                  state_d = SETTLE;
                  cnt_d   = 8'd1;
                  idx_d   = anIndex;
               end else begin
                  state_d = IDLE;
                  cnt_d   = 8'd0;
               end
            end else if (state_q == SETTLE) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 8'd0;
         end
      endcase
      if (state_d == SETTLE && cnt_d == SETTLE_LIM) begin
         capture = 1'b1;
         state_d = HELD;
      end
   end

   // Frame close, timeout expiry and the capture mask for the next cycle
   always_comb begin
      frameClose = (captured_q == 4'b1111);
      frameSame  = prevValid_q && (slots_q == prev_q);
      toReach    = !capture && (toCnt_q != TIMEOUT_LIM) && ((toCnt_q + 21'd1) == TIMEOUT_LIM);
      captured_d = captured_q;
      if (frameClose || toReach) begin
         captured_d = '0;
      end
      if (capture) begin
         captured_d[idx_d] = 1'b1;
      end
      match_d = match_q;
      if (frameClose) begin
         if (frameSame) begin
            match_d = (match_q == 4'hF) ? match_q : match_q + 4'd1;
         end else begin
            match_d = 4'd1;
         end
      end
   end

   // Slots, frame history, match counting, staging of a stable frame and the timeout
   always_ff @(posedge Clk100Mhz) begin
      if (rst) begin
         slots_q     <= '0;
         prev_q      <= '0;
         prevValid_q <= 1'b0;
         captured_q  <= '0;
         match_q     <= 4'd0;
         toCnt_q     <= 21'd0;
         locked_q    <= 1'b0;
         pubPend_q   <= 1'b0;
         stValue_q   <= 16'h0000;
         stDp_q      <= 4'b0000;
         stBlank_q   <= 4'b1111;
         stErr_q     <= 4'b0000;
      end else begin
         captured_q <= captured_d;
         match_q    <= match_d;
         if (capture) begin
            slots_q[idx_d] <= ~seg_q;
         end
         if (frameClose && !frameSame) begin
            prev_q      <= slots_q;
            prevValid_q <= 1'b1;
         end
         pubPend_q <= 1'b0;
         if (frameClose && match_d == STABLE_LIM) begin
            pubPend_q <= 1'b1;
            stValue_q <= decValue;
            stDp_q    <= decDp;
            stBlank_q <= decBlank;
            stErr_q   <= decErr;
         end
         if (capture) begin
            toCnt_q  <= 21'd0;
            locked_q <= 1'b1;
         end else if (toCnt_q != TIMEOUT_LIM) begin
            toCnt_q <= toCnt_q + 21'd1;
            if (toReach) begin
               locked_q <= 1'b0;
            end
         end
      end
   end

   // Publish a staged stable frame only if it differs from what is already shown
   always_ff @(posedge Clk100Mhz) begin
      if (rst) begin
         value_q  <= 16'h0000;
         dp_q     <= 4'b0000;
         blank_q  <= 4'b1111;
         err_q    <= 4'b0000;
         update_q <= 1'b0;
      end else begin
         update_q <= 1'b0;
         if (pubPend_q && ({stValue_q, stDp_q, stBlank_q, stErr_q} != {value_q, dp_q, blank_q, err_q})) begin
            value_q  <= stValue_q;
            dp_q     <= stDp_q;
            blank_q  <= stBlank_q;
            err_q    <= stErr_q;
            update_q <= 1'b1;
         end
      end
   end

   assign value  = value_q;
   assign dp     = dp_q;
   assign blank  = blank_q;
   assign err    = err_q;
   assign update = update_q;
   assign locked = locked_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed display scenarios plus random scans, with a
// pin-level reference model compared against the outputs on every cycle.
module tb_seg_scan_decoder;

   localparam int SETTLE  = 16;
   localparam int STABLE  = 3;
   localparam int TIMEOUT = 1000;

   localparam bit [6:0] GT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  seg;
   logic [3:0]  an;
   logic [15:0] value;
   logic [3:0]  dp, blank, err;
   logic        update, locked;

   int nChecks = 0;
   int nPass   = 0;
   int updCount = 0;
   bit modelReady = 1'b0;

   // reference model state
   logic [7:0]  mSlots [4];
   logic [7:0]  mPrev [4];
   bit          mPrevValid;
   logic [3:0]  mMask;
   int          mMatch;
   bit          mPend;
   logic [15:0] stValue;
   logic [3:0]  stDp, stBlank, stErr;
   logic [15:0] pubValue;
   logic [3:0]  pubDp, pubBlank, pubErr;
   bit          mUpd, mLocked;
   int          mTo;
   logic [3:0]  prevPin;
   int          runLen;
   bit          sched;
   int          schedIdx;
   logic [7:0]  schedGlyph;

   always #5 clk = ~clk;

   seg_scan_decoder #(
      .SETTLE_CYCLES  (SETTLE),
      .STABLE_FRAMES  (STABLE),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .Clk100Mhz (clk),
      .rst       (rst),
      .seg       (seg),
      .an        (an),
      .value     (value),
      .dp        (dp),
      .blank     (blank),
      .err       (err),
      .update    (update),
      .locked    (locked)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act === exp) begin
         nPass++;
      end else begin
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] a, input logic [7:0] s, input int cycles);
      an  = a;
      seg = s;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] pinsOf(input int hex, input bit dpLit);
      logic [7:0] g;
      g = {dpLit, GT[hex]};
      return ~g;
   endfunction

   function automatic logic [3:0] digitAn(input int d);
      logic [3:0] one;
      one = 4'b0001 << d;
      return ~one;
   endfunction

   task automatic scanFrame(input logic [7:0] p0, input logic [7:0] p1,
                            input logic [7:0] p2, input logic [7:0] p3, input int slotLen);
      applyStimulus(digitAn(0), p0, slotLen);
      applyStimulus(digitAn(1), p1, slotLen);
      applyStimulus(digitAn(2), p2, slotLen);
      applyStimulus(digitAn(3), p3, slotLen);
   endtask

   function automatic logic [7:0] randPins();
      int k;
      k = $urandom_range(0, 9);
      if (k <= 5) return pinsOf($urandom_range(0, 15), 1'($urandom_range(0, 1)));
      if (k == 6) return 8'hFF;
      if (k == 7) return 8'h7F;
      return 8'($urandom);
   endfunction

   // Reference model: a digit is captured one cycle after its anode pattern has been
   // held at the pins for SETTLE cycles; frames, matching and publishing follow from that.
   initial begin
      bit          doCap;
      int          capIdx;
      logic [7:0]  capGlyph;
      bit          same;
      bit          oneLow;
      int          lowIdx;
      forever begin
         @(posedge clk);
         if (rst) begin
            for (int d = 0; d < 4; d++) begin
               mSlots[d] = 8'h00;
               mPrev[d]  = 8'h00;
            end
            mPrevValid = 1'b0;
            mMask      = 4'b0000;
            mMatch     = 0;
            mPend      = 1'b0;
            pubValue   = 16'h0000;
            pubDp      = 4'b0000;
            pubBlank   = 4'b1111;
            pubErr     = 4'b0000;
            mUpd       = 1'b0;
            mLocked    = 1'b0;
            mTo        = 0;
            prevPin    = 4'hF;
            runLen     = 1;
            sched      = 1'b0;
         end else begin
            doCap    = sched;
            capIdx   = schedIdx;
            capGlyph = schedGlyph;
            if (mPend && ({stValue, stDp, stBlank, stErr} != {pubValue, pubDp, pubBlank, pubErr})) begin
               pubValue = stValue;
               pubDp    = stDp;
               pubBlank = stBlank;
               pubErr   = stErr;
               mUpd     = 1'b1;
            end else begin
               mUpd = 1'b0;
            end
            mPend = 1'b0;
            if (mMask == 4'b1111) begin
               same = mPrevValid;
               for (int d = 0; d < 4; d++) if (mSlots[d] != mPrev[d]) same = 1'b0;
               if (same) begin
                  if (mMatch < 15) mMatch++;
               end else begin
                  mMatch = 1;
                  for (int d = 0; d < 4; d++) mPrev[d] = mSlots[d];
                  mPrevValid = 1'b1;
               end
               if (mMatch == STABLE) begin
                  mPend = 1'b1;
                  for (int d = 0; d < 4; d++) begin
                     stDp[d]           = mSlots[d][7];
                     stBlank[d]        = (mSlots[d][6:0] == 7'h00);
                     stErr[d]          = !stBlank[d];
                     stValue[4*d +: 4] = 4'h0;
                     for (int h = 0; h < 16; h++) begin
                        if (mSlots[d][6:0] == GT[h]) begin
                           stErr[d]          = 1'b0;
                           stValue[4*d +: 4] = 4'(h);
                        end
                     end
                  end
               end
               mMask = 4'b0000;
            end
            if (doCap) begin
               mTo     = 0;
               mLocked = 1'b1;
            end else if (mTo != TIMEOUT) begin
               mTo++;
               if (mTo == TIMEOUT) begin
                  mLocked = 1'b0;
                  mMask   = 4'b0000;
               end
            end
            if (doCap) begin
               mSlots[capIdx] = capGlyph;
               mMask[capIdx]  = 1'b1;
            end
            if (an == prevPin) begin
               if (runLen < 100000) runLen++;
            end else begin
               runLen = 1;
            end
            prevPin = an;
            oneLow  = 1'b0;
            lowIdx  = 0;
            for (int d = 0; d < 4; d++) begin
               if (an == digitAn(d)) begin
                  oneLow = 1'b1;
                  lowIdx = d;
               end
            end
            sched      = oneLow && (runLen == SETTLE);
            schedIdx   = lowIdx;
            schedGlyph = ~seg;
         end
         modelReady = 1'b1;
      end
   end

   // Compare every output against the model each cycle, away from the clock edge
   always @(negedge clk) begin
      if (modelReady) begin
         checkOutput("outputs", {2'b00, value, dp, blank, err, update, locked},
                     {2'b00, pubValue, pubDp, pubBlank, pubErr, mUpd, mLocked});
      end
   end

   // Count publish pulses for the directed scenarios
   always @(negedge clk) begin
      if (update === 1'b1) updCount++;
   end

   initial begin
      logic [7:0] fr [4];
      logic [3:0] ovl [4];
      int         reps;
      ovl[0] = 4'b1100; ovl[1] = 4'b0000; ovl[2] = 4'b1111; ovl[3] = 4'b1010;
      rst = 1'b1;
      an  = 4'hF;
      seg = 8'hFF;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset value", 32'(value), 32'h0000);
      checkOutput("reset blank", 32'(blank), 32'hF);
      checkOutput("reset locked", 32'(locked), 32'h0);
      rst = 1'b0;

      // steady "1234"
      updCount = 0;
      repeat (3) scanFrame(pinsOf(4, 0), pinsOf(3, 0), pinsOf(2, 0), pinsOf(1, 0), 40);
      checkOutput("steady pulses", 32'(updCount), 32'd1);
      checkOutput("steady value", 32'(value), 32'h1234);
      checkOutput("steady blank/err", 32'({blank, err}), 32'h00);
      checkOutput("steady locked", 32'(locked), 32'h1);
      repeat (2) scanFrame(pinsOf(4, 0), pinsOf(3, 0), pinsOf(2, 0), pinsOf(1, 0), 40);
      checkOutput("steady no repeat", 32'(updCount), 32'd1);

      // change to "12A4"
      updCount = 0;
      repeat (2) scanFrame(pinsOf(4, 0), pinsOf(10, 0), pinsOf(2, 0), pinsOf(1, 0), 40);
      checkOutput("change early", 32'(updCount), 32'd0);
      scanFrame(pinsOf(4, 0), pinsOf(10, 0), pinsOf(2, 0), pinsOf(1, 0), 40);
      checkOutput("change pulses", 32'(updCount), 32'd1);
      checkOutput("change value", 32'(value), 32'h12A4);

      // short glitch then dp-only on digit 0
      updCount = 0;
      applyStimulus(digitAn(2), 8'hA5, 10);
      checkOutput("glitch ignored", 32'(updCount), 32'd0);
      repeat (3) scanFrame(8'h7F, pinsOf(10, 0), pinsOf(2, 0), pinsOf(1, 0), 40);
      checkOutput("dp-only pulses", 32'(updCount), 32'd1);
      checkOutput("dp-only value", 32'(value), 32'h12A0);
      checkOutput("dp-only blank", 32'(blank), 32'h1);
      checkOutput("dp-only dp", 32'(dp), 32'h1);

      // overlapping anodes and a bad glyph on digit 2
      updCount = 0;
      applyStimulus(4'b1100, pinsOf(8, 0), 30);
      for (int f = 0; f < 3; f++) begin
         applyStimulus(digitAn(0), pinsOf(4, 0), 40);
         applyStimulus(digitAn(1), pinsOf(3, 0), 40);
         applyStimulus(4'b1001, pinsOf(8, 1), 20);
         applyStimulus(digitAn(2), ~8'h27, 40);
         applyStimulus(digitAn(3), pinsOf(1, 0), 40);
      end
      checkOutput("bad glyph pulses", 32'(updCount), 32'd1);
      checkOutput("bad glyph err", 32'(err), 32'h4);
      checkOutput("bad glyph value", 32'(value), 32'h1034);

      // timeout with outputs held
      applyStimulus(4'hF, 8'hFF, TIMEOUT + 1);
      checkOutput("timeout locked", 32'(locked), 32'h0);
      checkOutput("timeout value held", 32'(value), 32'h1034);
      checkOutput("timeout err held", 32'(err), 32'h4);

      // reset in the middle of a scan
      applyStimulus(digitAn(0), pinsOf(5, 0), 40);
      applyStimulus(digitAn(1), pinsOf(6, 0), 20);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midreset value", 32'(value), 32'h0000);
      checkOutput("midreset flags", 32'({dp, blank, err, update, locked}), 32'({4'h0, 4'hF, 4'h0, 2'b00}));
      rst = 1'b0;

      // randomized scans with repeated frames so some become stable
      for (int p = 0; p < 8; p++) begin
         for (int d = 0; d < 4; d++) fr[d] = randPins();
         reps = $urandom_range(2, 5);
         for (int r = 0; r < reps; r++) begin
            for (int d = 0; d < 4; d++) begin
               if ($urandom_range(0, 7) == 0) begin
                  applyStimulus(ovl[$urandom_range(0, 3)], 8'($urandom), $urandom_range(3, 20));
               end
               applyStimulus(digitAn(d), fr[d], $urandom_range(8, 40));
            end
         end
      end
      repeat (5) @(posedge clk);
      #1;

      $display("[TB] %0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive side of the game's multiplexed 7-segment display bus: watches the scanned `seg`/`an` lines exactly as driven to the board, recovers the four displayed hex digits, and presents them as a stable 16-bit value. It sits in self-check benches and in the on-chip debug path, so the score/state shown on the display can be compared against expected values without a camera or a human.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 16: cycles an anode pattern must hold before `seg` is sampled; 1..255.
- `STABLE_FRAMES`, default 3: consecutive identical complete frames required before a new value is published; 1..15.
- `TIMEOUT_CYCLES`, default 1048576: cycles without any digit capture before `locked` drops; the counter is 21 bits wide.

Ports:
- `Clk100Mhz`  in  1  system clock, 100 MHz.
- `rst`  in  1  synchronous reset, active-high.
- `seg`  in  8  segment lines, active-low; bit0..6 = a..g, bit7 = dp.
- `an`  in  4  anode enables, active-low; an[0] = rightmost digit.
- `value`  out  16  published digits; value[3:0] = digit 0 (rightmost).
- `dp`  out  4  published decimal points, 1 = lit.
- `blank`  out  4  digit showed no segments (value nibble = 0).
- `err`  out  4  digit showed an unrecognised glyph (value nibble = 0).
- `update`  out  1  one-cycle pulse when published outputs change.
- `locked`  out  1  high while digits are being captured within the timeout.

## Operation
- Inputs are registered once (`seg_q`, `an_q`); all logic below uses the registered copies.
- Anode tracker FSM, states IDLE, SETTLE, HELD:
  - IDLE: `an_q` is not exactly one-low (all-high, or two or more lows). Counter is cleared.
  - IDLE -> SETTLE when `an_q` becomes one-low. The counter is loaded with 1 and the digit index is latched.
  - SETTLE: while `an_q` is unchanged, the counter increments. When the counter reaches SETTLE_CYCLES, the digit is captured and the FSM moves to HELD.
  - HELD: waits for `an_q` to change.
  - From SETTLE or HELD, any change of `an_q` goes to SETTLE with the new index if the new pattern is one-low, otherwise to IDLE. A change during SETTLE discards the partial count.
- Capture:
  - Stores the raw 8-bit glyph (`~seg_q`) into slot[index] and sets captured[index].
  - A repeat capture of the same index before the frame closes overwrites the slot.
- Glyph decode uses active-high gfedcba and must match exactly:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - 00 means blank.
  - Any other pattern sets err.
  - dp is taken separately from bit7.
- Frame close happens when captured == 4'b1111:
  - The four raw glyphs are compared with the previous frame's glyphs.
  - Equal: the match counter increments, saturating at 15. Different: the match counter is set to 1 and the previous-frame glyphs are replaced.
  - captured is cleared in the same cycle.
- Publish: when the match counter reaches STABLE_FRAMES and the decoded frame differs from the published outputs (`value`, `dp`, `blank`, `err`), the outputs are loaded and `update` pulses. A stable frame identical to the published outputs produces no pulse.
- Timeout counter: cleared on every capture. On reaching TIMEOUT_CYCLES it holds, `locked` goes to 0, and captured is cleared. `locked` returns to 1 on the next capture. Published outputs are held across a timeout.

## Timing
- Reset values: `value` 16'h0000, `dp` 4'b0000, `blank` 4'b1111, `err` 4'b0000, `update` 0, `locked` 0.
- Reset also clears the FSM (to IDLE), captured, all slots, the previous-frame glyphs, the match counter and the timeout counter.
- Reset mid-scan discards the partial frame. The first frame after reset never matches, because it is compared against an invalid previous frame.
- Capture latency:
  - `an` changes at the pins at cycle N; `an_q` changes at N+1.
  - The capture writes the slot at the edge ending cycle N+SETTLE_CYCLES.
- Frame close happens one cycle after the fourth capture.
- Publish and the `update` pulse are registered one cycle after the frame close that reaches STABLE_FRAMES.
- Simultaneous capture and frame close: the close uses the pre-capture mask, and the new capture sets its bit in the cleared mask.
- `update` is never high on two consecutive cycles.

## Structure
- `seg_pkg` holds:
  - the glyph constants (GLYPH_0..GLYPH_F, GLYPH_BLANK);
  - the FSM state enum;
  - the digit-count constant NUM_DIGITS = 4.
- Sub-module `seg_glyph_decode` is combinational: 8-bit raw glyph in; 4-bit nibble, dp, blank and err out. It is instantiated four times on the frame slots.
- The top module contains the input registers, the anode FSM, the slots, the frame compare, the publish logic and the timeout.

## Test plan
- **Steady display.** After reset, drive a 4-digit scan of "1234" with 40-cycle digit slots, SETTLE_CYCLES=16.
  - Required: one `update` pulse after the 3rd complete frame.
  - Then `value`=16'h1234, `blank`=0, `err`=0, `locked`=1.
  - Further identical frames give no further pulse.
- **Value change.** Switch the scan from "1234" to "12A4".
  - Required: exactly one `update`, 3 frames after the switch, with `value`=16'h12A4.
- **Short glitch.** Drive an anode slot of 10 cycles, shorter than SETTLE_CYCLES, carrying a garbage glyph. Then set digit 0 to dp-only (seg=8'h7F).
  - Required: no capture and no change from the glitch slot.
  - After the dp-only frames are stable: `blank[0]`=1, `dp[0]`=1, `value[3:0]`=0.
- **Overlap and bad glyph.**
  - Two anodes low together: ignored, FSM in IDLE.
  - Glyph 0x27 on digit 2: `err[2]`=1 and `value[11:8]`=0 once stable.
- **Timeout and reset.**
  - Hold `an`=4'hF for TIMEOUT_CYCLES+1 cycles: `locked` goes to 0 and `value` is held.
  - Assert `rst` during the next scan: all outputs return to their reset values the next cycle.
